// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the AHB decoder/mux slice.
//   - HTRANS encodings (TRANS_*)
//   - HRESP encodings (RESP_*)
//   - ds_state_t: default-slave FSM states
//   - is_active(): true for a transfer that needs a real data phase (NONSEQ/SEQ)
package bus_decoder_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == TRANS_NONSEQ) || (trans == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers every NONSEQ/SEQ transfer that decodes to no
// real slave with the two-cycle AHB ERROR response (wait+ERROR, ready+ERROR).
// IDLE/BUSY to the default slave complete with zero waits and OKAY.
// Optional macro DECODER_ERR_CNT_EN adds a saturating 16-bit error counter.
// Ports:
//   HCLK, HRESET  clock, synchronous active-high reset
//   sel_default   address-phase decode targets the default slave
//   HTRANS        address-phase transfer type
//   HREADY        muxed bus ready (address phase is accepted when high)
//   ds_hready     default-slave HREADYOUT
//   ds_hresp      default-slave HRESP
//   ERR_COUNT     (DECODER_ERR_CNT_EN only) number of ERROR responses started
module ahb_default_slave
    import bus_decoder_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        sel_default,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    output logic        ds_hready,
    output logic        ds_hresp
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [15:0] ERR_COUNT
`endif
);

    ds_state_t state, state_next;
    logic      accept_err;

    // A default-slave transfer that needs a real data phase is accepted.
    assign accept_err = HREADY && sel_default && is_active(HTRANS);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= DS_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            DS_IDLE: if (accept_err) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = accept_err ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    // Outputs depend on state only, so the bus HREADY feedback into
    // accept_err never forms a combinational path back to ds_hready.
    assign ds_hready = (state != DS_ERR1);
    assign ds_hresp  = (state == DS_IDLE) ? RESP_OKAY : RESP_ERROR;

`ifdef DECODER_ERR_CNT_EN
    // Counts entries into DS_ERR1; from DS_ERR1 the FSM always leaves, so
    // next==DS_ERR1 with current!=DS_ERR1 is exactly one new error.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            ERR_COUNT <= '0;
        else if (state_next == DS_ERR1 && state != DS_ERR1 && ERR_COUNT != 16'hFFFF)
            ERR_COUNT <= ERR_COUNT + 16'd1;
    end
`endif

endmodule

// File: rtl/ahb_decoder_mux.sv
// Parametrised AHB address decoder and slave response multiplexer.
// Decodes the slave-select field into one-hot HSEL, registers the data-phase
// owner (dsel) whenever HREADY is high, and muxes HRDATA/HREADY/HRESP back to
// the master. Select values >= NUM_SLAVES route to a built-in default slave
// that returns ERROR.
// Optional macro DECODER_ERR_CNT_EN adds the ERR_COUNT output.
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   HADDR_SLAVE_SEL_BITS   address-phase slave-select field
//   HTRANS                 address-phase transfer type
//   HSEL                   one-hot slave select (slave 0 during reset)
//   HRDATA_S/HREADYOUT_S/HRESP_S  per-slave data-phase responses (flattened)
//   HRDATA/HREADY/HRESP    muxed response to master (HREADY also to slaves)
//   ERR_COUNT              (DECODER_ERR_CNT_EN only) default-slave error count
module ahb_decoder_mux
    import bus_decoder_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LEN    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [SEL_LEN-1:0]               HADDR_SLAVE_SEL_BITS,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP
`ifdef DECODER_ERR_CNT_EN
    ,
    output logic [15:0]                      ERR_COUNT
`endif
);

    // dsel code NUM_SLAVES means "default slave".
    localparam int               DSEL_W   = $clog2(NUM_SLAVES + 1);
    localparam logic [DSEL_W-1:0] DSEL_DEF = DSEL_W'(NUM_SLAVES);

    logic [DSEL_W-1:0] tgt;
    logic [DSEL_W-1:0] dsel;
    logic              sel_default;
    logic              ds_hready;
    logic              ds_hresp;

    // Address-phase decode. Out-of-range selects leave HSEL all-zero and
    // target the default slave.
    always_comb begin
        tgt  = DSEL_DEF;
        HSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(HADDR_SLAVE_SEL_BITS) == i) begin
                tgt     = DSEL_W'(i);
                HSEL[i] = 1'b1;
            end
        end
        if (HRESET) HSEL = NUM_SLAVES'(1);
    end

    assign sel_default = (tgt == DSEL_DEF);

    // Ownership follows every accepted address phase, IDLE included.
    always_ff @(posedge HCLK) begin
        if (HRESET)      dsel <= '0;
        else if (HREADY) dsel <= tgt;
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = RESP_OKAY;
        if (!HRESET) begin
            if (dsel == DSEL_DEF) begin
                HREADY = ds_hready;
                HRESP  = ds_hresp;
            end else begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (dsel == DSEL_W'(i)) begin
                        HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                        HREADY = HREADYOUT_S[i];
                        HRESP  = HRESP_S[i];
                    end
                end
            end
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .sel_default (sel_default),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .ds_hready   (ds_hready),
        .ds_hresp    (ds_hresp)
`ifdef DECODER_ERR_CNT_EN
        ,
        .ERR_COUNT   (ERR_COUNT)
`endif
    );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Testbench for ahb_decoder_mux (NUM_SLAVES=3, SEL_LEN=2, DATA_WIDTH=32).
// Directed scenarios followed by random traffic, each cycle compared against a
// transaction-level model: who owns the data phase and how many cycles of an
// error response remain.
module tb_ahb_decoder_mux;
    localparam int NS = 3;
    localparam int SL = 2;
    localparam int DW = 32;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [SL-1:0]     sel;
    logic [1:0]        htrans;
    logic [NS-1:0]     hsel;
    logic [NS*DW-1:0]  rdata_s;
    logic [NS-1:0]     rdy_s;
    logic [NS-1:0]     resp_s;
    logic [DW-1:0]     hrdata;
    logic              hready;
    logic              hresp;
`ifdef DECODER_ERR_CNT_EN
    logic [15:0]       err_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: owner of the current data phase (NS = default slave), and the
    // position inside a default-slave error response (0 none, 1 first, 2 second).
    int m_owner    = 0;
    int m_err_pos  = 0;
    int m_errs     = 0;

    always #5 HCLK = ~HCLK;

    ahb_decoder_mux #(.NUM_SLAVES(NS), .SEL_LEN(SL), .DATA_WIDTH(DW)) dut (
        .HCLK                 (HCLK),
        .HRESET               (HRESET),
        .HADDR_SLAVE_SEL_BITS (sel),
        .HTRANS               (htrans),
        .HSEL                 (hsel),
        .HRDATA_S             (rdata_s),
        .HREADYOUT_S          (rdy_s),
        .HRESP_S              (resp_s),
        .HRDATA               (hrdata),
        .HREADY               (hready),
        .HRESP                (hresp)
`ifdef DECODER_ERR_CNT_EN
        ,
        .ERR_COUNT            (err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_slaves();
        for (int i = 0; i < NS; i++) begin
            rdata_s[i*DW +: DW] = $urandom;
            rdy_s[i]  = ($urandom_range(0, 3) != 0);
            resp_s[i] = ($urandom_range(0, 7) == 0);
        end
    endtask

    // One bus cycle: check outputs at the falling edge, advance the model at
    // the rising edge, leave room to change inputs afterwards.
    task automatic step(input string tag);
        logic [NS-1:0] e_hsel;
        logic          e_rdy, e_resp, active;
        logic [DW-1:0] e_data;
        int            s;
        @(negedge HCLK);
        s = int'(sel);
        e_hsel = '0;
        if (HRESET)      e_hsel[0] = 1'b1;
        else if (s < NS) e_hsel[s] = 1'b1;

        if (HRESET) begin
            e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
        end else if (m_owner < NS) begin
            e_rdy  = rdy_s[m_owner];
            e_resp = resp_s[m_owner];
            e_data = rdata_s[m_owner*DW +: DW];
        end else begin
            e_data = '0;
            e_rdy  = (m_err_pos != 1);
            e_resp = (m_err_pos != 0);
        end

        chk({tag, ".hsel"},   hsel,   e_hsel);
        chk({tag, ".hready"}, hready, e_rdy);
        chk({tag, ".hresp"},  hresp,  e_resp);
        chk({tag, ".hrdata"}, hrdata, e_data);
`ifdef DECODER_ERR_CNT_EN
        chk({tag, ".err_count"}, err_count, 64'(m_errs));
`endif

        @(posedge HCLK);
        if (HRESET) begin
            m_owner = 0; m_err_pos = 0; m_errs = 0;
        end else begin
            active = htrans[1];
            if (m_err_pos == 1) begin
                m_err_pos = 2;
            end else if (e_rdy && s >= NS && active) begin
                m_err_pos = 1;
                if (m_errs < 65535) m_errs++;
            end else begin
                m_err_pos = 0;
            end
            if (e_rdy) m_owner = (s < NS) ? s : NS;
        end
        #1;
    endtask

    initial begin
        HRESET = 1'b1; sel = '0; htrans = 2'b00;
        rdata_s = '0; rdy_s = '1; resp_s = '0;

        // Reset with toggling slave inputs.
        for (int c = 0; c < 3; c++) begin
            rand_slaves(); sel = SL'($urandom); htrans = 2'($urandom);
            step("reset");
        end
        HRESET = 1'b0; sel = 2'd0; htrans = 2'b00; rdy_s = '1; resp_s = '0;
        rdata_s[0 +: DW] = 32'h0000_B007;
        step("post_reset");

        // NONSEQ to slave 1 with two wait states.
        sel = 2'd1; htrans = 2'b10;
        step("s1_addr");
        sel = 2'd0; htrans = 2'b00;
        rdata_s[1*DW +: DW] = 32'hA5A5_0001; rdy_s[1] = 1'b0;
        step("s1_wait1");
        step("s1_wait2");
        rdy_s[1] = 1'b1;
        step("s1_done");

        // Single unmapped NONSEQ.
        sel = 2'd3; htrans = 2'b10;
        step("def_addr");
        sel = 2'd0; htrans = 2'b00;
        step("def_err1");
        step("def_err2");
        step("def_okay");

        // Back-to-back unmapped NONSEQs.
        sel = 2'd3; htrans = 2'b10;
        step("b2b_addr");
        step("b2b_err1a");
        step("b2b_err2a");
        sel = 2'd0; htrans = 2'b00;
        step("b2b_err1b");
        step("b2b_err2b");

        // IDLE to the unmapped region: zero-wait OKAY.
        sel = 2'd3; htrans = 2'b00;
        step("idle_def");
        sel = 2'd0;
        step("idle_def_data");

        // Reset during an error response.
        sel = 2'd3; htrans = 2'b11;
        step("rst_addr");
        HRESET = 1'b1; sel = 2'd0; htrans = 2'b00;
        step("rst_in_err1");
        HRESET = 1'b0;
        step("rst_after");
        step("rst_after2");

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            HRESET = ($urandom_range(0, 49) == 0);
            sel    = SL'($urandom);
            htrans = 2'($urandom);
            rand_slaves();
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
Parametrised successor to the 3-slave combinational AHB decoder.
- Decodes the slave-select address bits into a one-hot HSEL vector for NUM_SLAVES slaves.
- Registers the data-phase target and multiplexes slave HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that returns a two-cycle AHB ERROR for any unmapped transfer.
- Sits between the master interface and the slaves in the bus fabric.

Parameters:
- NUM_SLAVES, 3, number of real slaves; legal range 1..2**SEL_LEN.
- SEL_LEN, 2, width of the slave-select address field.
- DATA_WIDTH, 32, read-data width per slave.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HADDR_SLAVE_SEL_BITS  in  SEL_LEN  address-phase slave-select field.
- HTRANS  in  2  address-phase transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HSEL  out  NUM_SLAVES  one-hot address-phase slave select.
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  flattened slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- HRESP_S  in  NUM_SLAVES  per-slave response (0=OKAY, 1=ERROR).
- HRDATA  out  DATA_WIDTH  muxed read data to master.
- HREADY  out  1  muxed ready to master and slaves.
- HRESP  out  1  muxed response to master.

Behaviour:
Address-phase decode (combinational):
- HSEL[i]=1 when HADDR_SLAVE_SEL_BITS==i, for i<NUM_SLAVES.
- Any select value >=NUM_SLAVES targets the default slave; HSEL is all-zero in that case.
- While HRESET=1, HSEL is forced to one-hot slave 0 (boot target).

Data-phase register dsel (width clog2(NUM_SLAVES+1); code NUM_SLAVES = default slave):
- Loads the decoded target on any edge where HREADY=1. This is independent of HTRANS, so an IDLE transfer also moves ownership.
- Holds its value while HREADY=0.
- Reset value is 0.

Response mux:
- dsel<NUM_SLAVES: HRDATA/HREADY/HRESP are taken from slave dsel.
- dsel==default: HRDATA=0; HREADY/HRESP come from the default slave FSM.
- While HRESET=1: HREADY=1, HRESP=0, HRDATA=0, regardless of the slave inputs.

Default slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2; reset to DS_IDLE):
- DS_IDLE: outputs HREADY=1, HRESP=0. Go to DS_ERR1 when HREADY=1, HTRANS is NONSEQ or SEQ, and the decode targets the default slave. Otherwise stay.
- DS_ERR1: outputs HREADY=0, HRESP=1. Unconditionally go to DS_ERR2.
- DS_ERR2: outputs HREADY=1, HRESP=1. Go to DS_ERR1 if a new default-slave NONSEQ/SEQ is accepted this cycle; otherwise go to DS_IDLE.
- IDLE or BUSY transfers to the default slave complete with zero wait states and OKAY.

Boundaries:
- Back-to-back unmapped transfers give a continuous ERR1, ERR2, ERR1, ERR2 sequence.
- Reset asserted mid-error returns the FSM to DS_IDLE and dsel to 0 on the next edge.
- NUM_SLAVES==2**SEL_LEN makes the default slave unreachable. This is legal and the FSM stays in DS_IDLE.
- With NUM_SLAVES=3 and SEL_LEN=2, select value 11 goes to the default slave and returns ERROR.

Optional Feature:
DECODER_ERR_CNT_EN
- Defined:
  - Adds output ERR_COUNT, 16 bits.
  - Increments on each DS_IDLE->DS_ERR1 or DS_ERR2->DS_ERR1 transition.
  - Saturates at 16'hFFFF and clears on HRESET.
- Undefined: no port and no counter logic.

Decomposition:
- Package bus_decoder_pkg holds:
  - HTRANS constants (TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ)
  - HRESP constants (RESP_OKAY, RESP_ERROR)
  - enum ds_state_t {DS_IDLE, DS_ERR1, DS_ERR2}
- Sub-module ahb_default_slave holds the FSM and the optional counter.
  - Inputs: HCLK, HRESET, sel_default, HTRANS, HREADY.
  - Outputs: ds_hready, ds_hresp, and ERR_COUNT when DECODER_ERR_CNT_EN is defined.

Test Plan:
- Reset held 3 cycles with slave inputs toggling: HSEL=001, HREADY=1, HRESP=0, HRDATA=0 throughout; dsel=0 after release.
- NONSEQ to sel=01 with slave1 HRDATA=32'hA5A5_0001 and HREADYOUT_S[1]=0 for 2 cycles: HSEL=010 in the address phase; HREADY low for 2 cycles; then HRDATA=A5A5_0001, HRESP=0.
- NONSEQ to sel=11 (NUM_SLAVES=3): HSEL=000; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1; then OKAY.
- Two consecutive NONSEQ to sel=11: ERR1, ERR2, ERR1, ERR2; with DECODER_ERR_CNT_EN defined, ERR_COUNT=2.
- IDLE transfer to sel=11: zero-wait, HRESP=0, FSM stays in DS_IDLE, ERR_COUNT unchanged.
- HRESET asserted during DS_ERR1: next cycle HREADY=1, HRESP=0, FSM in DS_IDLE, ERR_COUNT=0.
